// File: rtl/i2s_rx_deser_if.sv
// Bundle between the I2S capture front-end and its surroundings: the raw serial pins
// and the capture enable on one side, and the packed stereo word with its strobes on the other.
interface i2s_rx_deser_if #(
    parameter int DATA_W = 16
);
    logic                  enable;
    logic                  bclk;
    logic                  lrck;
    logic                  sdata;
    logic [2*DATA_W-1:0]   audio_out;
    logic                  valid_out;
    logic                  frame_err;

    // master: the deserialiser, which owns the packed output word
    modport master (
        input  enable, bclk, lrck, sdata,
        output audio_out, valid_out, frame_err
    );

    // slave: the ADC/serial side that feeds pins and consumes the frames
    modport slave (
        output enable, bclk, lrck, sdata,
        input  audio_out, valid_out, frame_err
    );
endinterface

// File: rtl/i2s_rx_deser.sv
// Philips I2S receiver: oversamples BCLK/LRCK/SDATA in the clk domain and packs one
// {left, right} word per frame with a one-cycle valid strobe and a short-word error strobe.
module i2s_rx_deser #(
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    i2s_rx_deser_if.master bus
);
    localparam int                 CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DATA_W);

    // Two-flop synchronisers; bit 0 = bclk, bit 1 = lrck, bit 2 = sdata
    logic [2:0] pin_raw;
    wire  [2:0] pin_s2;

    assign pin_raw = {bus.sdata, bus.lrck, bus.bclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= pin_raw[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign pin_s2[gi] = s2_reg;
        end
    endgenerate

    logic bclk_s2;
    logic lrck_s2;
    logic sdata_s2;
    logic bclk_s3_reg;
    logic rise;

    assign bclk_s2  = pin_s2[0];
    assign lrck_s2  = pin_s2[1];
    assign sdata_s2 = pin_s2[2];
    assign rise     = bclk_s2 & ~bclk_s3_reg;

    logic                  lr_prev_reg,   lr_prev_next;
    logic [CNT_W-1:0]      bit_cnt_reg,   bit_cnt_next;
    logic [DATA_W-1:0]     shreg_reg,     shreg_next;
    logic [DATA_W-1:0]     left_hold_reg, left_hold_next;
    logic                  left_ok_reg,   left_ok_next;
    logic                  synced_reg,    synced_next;
    logic [2*DATA_W-1:0]   audio_reg,     audio_next;
    logic                  valid_reg,     valid_next;
    logic                  err_reg,       err_next;

    // Candidate shift for this rise; bits past DATA_W are dropped so long words truncate
    logic                  shift_ok;
    logic [DATA_W-1:0]     shreg_shift;
    logic [CNT_W-1:0]      cnt_shift;

    always_comb begin
        shift_ok    = (bit_cnt_reg < CNT_FULL);
        shreg_shift = shreg_reg;
        cnt_shift   = bit_cnt_reg;
        if (shift_ok) begin
            shreg_shift = {shreg_reg[DATA_W-2:0], sdata_s2};
            cnt_shift   = bit_cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        lr_prev_next   = lr_prev_reg;
        bit_cnt_next   = bit_cnt_reg;
        shreg_next     = shreg_reg;
        left_hold_next = left_hold_reg;
        left_ok_next   = left_ok_reg;
        synced_next    = synced_reg;
        audio_next     = audio_reg;
        valid_next     = 1'b0;
        err_next       = 1'b0;

        if (!bus.enable) begin
            // Tracking lr_prev here keeps the enable edge from looking like a word boundary
            bit_cnt_next = '0;
            shreg_next   = '0;
            left_ok_next = 1'b0;
            synced_next  = 1'b0;
            lr_prev_next = lrck_s2;
        end else if (rise) begin
            if (lrck_s2 == lr_prev_reg) begin
                shreg_next   = shreg_shift;
                bit_cnt_next = cnt_shift;
            end else begin
                // Boundary rise still carries the outgoing channel's LSB slot
                if (!synced_reg) begin
                    synced_next = 1'b1;
                end else if (cnt_shift < CNT_FULL) begin
                    err_next     = 1'b1;
                    left_ok_next = 1'b0;
                end else if (!lr_prev_reg) begin
                    left_hold_next = shreg_shift;
                    left_ok_next   = 1'b1;
                end else begin
                    if (left_ok_reg) begin
                        audio_next = {left_hold_reg, shreg_shift};
                        valid_next = 1'b1;
                    end
                    left_ok_next = 1'b0;
                end
                bit_cnt_next = '0;
                shreg_next   = '0;
                lr_prev_next = lrck_s2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_s3_reg   <= 1'b0;
            lr_prev_reg   <= 1'b0;
            bit_cnt_reg   <= '0;
            shreg_reg     <= '0;
            left_hold_reg <= '0;
            left_ok_reg   <= 1'b0;
            synced_reg    <= 1'b0;
            audio_reg     <= '0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            bclk_s3_reg   <= bclk_s2;
            lr_prev_reg   <= lr_prev_next;
            bit_cnt_reg   <= bit_cnt_next;
            shreg_reg     <= shreg_next;
            left_hold_reg <= left_hold_next;
            left_ok_reg   <= left_ok_next;
            synced_reg    <= synced_next;
            audio_reg     <= audio_next;
            valid_reg     <= valid_next;
            err_reg       <= err_next;
        end
    end

    assign bus.audio_out = audio_reg;
    assign bus.valid_out = valid_reg;
    assign bus.frame_err = err_reg;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: drives Philips-format frames segment by segment and scores the
// observed strobes (kind, data, latency from the carrying BCLK rise) against expectations.
module tb_i2s_rx_deser;
    localparam int DATA_W = 16;
    localparam int W2     = 2 * DATA_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    i2s_rx_deser_if #(.DATA_W(DATA_W)) bus ();

    i2s_rx_deser #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Event kinds: 1 valid, 2 frame_err, 3 strobe wider than 1 clk, 4 audio changed without valid
    typedef struct {
        int          kind;
        logic [31:0] data;
        int          lat;
    } ev_t;

    typedef struct {
        logic [31:0] lv, rv;
        int          ld, rd, ln, rn;
        bit          e_err, e_val;
        logic [31:0] e_audio;
    } fvec_t;

    ev_t   exp_q[$];
    ev_t   act_q[$];
    fvec_t tab[10];

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int half = 8;
    logic pending = 1'b0;

    // Reference state, one step per completed channel word
    bit          en_now = 1'b0;
    bit          use_model = 1'b0;
    bit          m_synced = 1'b0;
    bit          m_left_ok = 1'b0;
    logic [15:0] m_left = '0;
    bit          have_prev = 1'b0;
    int          p_ch, p_n, p_d;
    logic [31:0] p_val;

    logic            prev_valid = 1'b0;
    logic            prev_err = 1'b0;
    logic [W2-1:0]   prev_audio = '0;

    function automatic ev_t mk_ev(input int kind, input logic [31:0] data, input int lat);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.lat  = lat;
        return e;
    endfunction

    function automatic logic [63:0] pack_ev(input ev_t e);
        return {4'(e.kind), 12'(e.lat), 16'h0, e.data};
    endfunction

    function automatic fvec_t mkv(input logic [31:0] lv, input int ld, input int ln,
                                  input logic [31:0] rv, input int rd, input int rn,
                                  input bit e_err, input bit e_val, input logic [31:0] e_audio);
        fvec_t v;
        v.lv = lv; v.ld = ld; v.ln = ln;
        v.rv = rv; v.rd = rd; v.rn = rn;
        v.e_err = e_err; v.e_val = e_val; v.e_audio = e_audio;
        return v;
    endfunction

    // MSB-first data left-justified in the slot; only the first DATA_W slots survive
    function automatic logic [15:0] captured(input logic [31:0] val, input int d);
        if (d >= DATA_W) return 16'(val >> (d - DATA_W));
        else             return 16'(val << (DATA_W - d));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid_out) act_q.push_back(mk_ev(1, bus.audio_out, cyc - rise_cyc));
            if (bus.frame_err) act_q.push_back(mk_ev(2, 32'h0, cyc - rise_cyc));
            if ((bus.valid_out && prev_valid) || (bus.frame_err && prev_err))
                act_q.push_back(mk_ev(3, bus.audio_out, cyc - rise_cyc));
            if (!bus.valid_out && bus.audio_out != prev_audio)
                act_q.push_back(mk_ev(4, bus.audio_out, cyc - rise_cyc));
        end
        prev_valid <= bus.valid_out;
        prev_err   <= bus.frame_err;
        prev_audio <= bus.audio_out;
    end

    task automatic model_clear();
        m_synced  = 1'b0;
        m_left_ok = 1'b0;
    endtask

    // Called when the previous channel word completes (first rise of the next segment)
    task automatic model_end();
        logic [15:0] word;
        if (!have_prev || !en_now) return;
        word = captured(p_val, p_d);
        if (!m_synced) begin
            m_synced = 1'b1;
        end else if (p_n < DATA_W) begin
            if (use_model) exp_q.push_back(mk_ev(2, 32'h0, 3));
            m_left_ok = 1'b0;
        end else if (p_ch == 0) begin
            m_left    = word;
            m_left_ok = 1'b1;
        end else begin
            if (m_left_ok && use_model) exp_q.push_back(mk_ev(1, {m_left, word}, 3));
            m_left_ok = 1'b0;
        end
    endtask

    task automatic do_event(input int kind);
        if (kind == 1) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mid_audio", 64'(bus.audio_out), 64'd0);
            chk("rst_mid_valid", 64'(bus.valid_out), 64'd0);
            chk("rst_mid_err",   64'(bus.frame_err), 64'd0);
            @(posedge clk);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            model_clear();
        end else if (kind == 2) begin
            bus.enable = 1'b0;
            en_now = 1'b0;
            model_clear();
        end else if (kind == 3) begin
            bus.enable = 1'b1;
            en_now = 1'b1;
        end
    endtask

    // One channel segment of n BCLKs; SDATA lags LRCK by one bit (Philips timing)
    task automatic send_segment(input int ch, input logic [31:0] val, input int d,
                                input int n, input int ev_at, input int ev_kind);
        model_end();
        for (int j = 0; j < n; j++) begin
            bus.bclk  = 1'b0;
            bus.lrck  = ch[0];
            bus.sdata = pending;
            pending   = (j < d) ? val[d-1-j] : 1'b0;
            for (int k = 0; k < half; k++) begin
                @(posedge clk);
                #1;
                if (j == ev_at && k == 1) do_event(ev_kind);
            end
            bus.bclk = 1'b1;
            if (j == 0) rise_cyc = cyc;
            for (int k = 0; k < half; k++) begin
                @(posedge clk);
                #1;
            end
        end
        have_prev = 1'b1;
        p_ch  = ch;
        p_val = val;
        p_d   = d;
        p_n   = n;
    endtask

    task automatic send_random_segment(input int ch);
        int          sel, n, d;
        logic [31:0] val;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      n = int'($urandom_range(8, 15));
        else if (sel == 1) n = 16;
        else if (sel == 2) n = 17;
        else if (sel == 3) n = 24;
        else               n = 32;
        if (n < DATA_W) d = n;
        else            d = 12 + 4 * int'($urandom_range(0, 3));
        if (d > n) d = n;
        val = $urandom & ((32'h1 << d) - 32'h1);
        send_segment(ch, val, d, n, -1, 0);
    endtask

    initial begin
        ev_t dummy;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.bclk   = 1'b0;
        bus.lrck   = 1'b0;
        bus.sdata  = 1'b0;

        tab[0] = mkv(32'h1111,   16, 32, 32'h2222,   16, 32, 0, 0, 32'h0);
        tab[1] = mkv(32'h1234,   16, 32, 32'hABCD,   16, 32, 0, 1, 32'h1234ABCD);
        tab[2] = mkv(32'h8000,   16, 32, 32'h7FFF,   16, 32, 0, 1, 32'h80007FFF);
        tab[3] = mkv(32'hFFFF,   16, 32, 32'h0001,   16, 32, 0, 1, 32'hFFFF0001);
        tab[4] = mkv(32'h02AA,   10, 10, 32'h5555,   16, 32, 1, 0, 32'h0);
        tab[5] = mkv(32'hCAFE,   16, 32, 32'hBEEF,   16, 32, 0, 1, 32'hCAFEBEEF);
        tab[6] = mkv(32'hA5A55A, 24, 32, 32'h0F0FF0, 24, 32, 0, 1, 32'hA5A50F0F);
        tab[7] = mkv(32'h1357,   16, 16, 32'h2468,   16, 16, 0, 1, 32'h13572468);
        tab[8] = mkv(32'h1111,   16, 32, 32'h1234,   15, 15, 1, 0, 32'h0);
        tab[9] = mkv(32'h0F0F,   16, 32, 32'hF0F0,   16, 32, 0, 1, 32'h0F0FF0F0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_audio", 64'(bus.audio_out), 64'd0);
        chk("reset_valid", 64'(bus.valid_out), 64'd0);
        chk("reset_err",   64'(bus.frame_err), 64'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        en_now     = 1'b1;
        @(posedge clk);
        #1;

        // Directed frames from the table, clk = 16x BCLK
        half = 8;
        use_model = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tab[i].e_err) exp_q.push_back(mk_ev(2, 32'h0, 3));
            if (tab[i].e_val) exp_q.push_back(mk_ev(1, tab[i].e_audio, 3));
            send_segment(0, tab[i].lv, tab[i].ld, tab[i].ln, -1, 0);
            send_segment(1, tab[i].rv, tab[i].rd, tab[i].rn, -1, 0);
        end

        // Drop enable mid-left, re-enable mid-left one frame later
        send_segment(0, 32'h4444, 16, 32, 5, 2);
        use_model = 1'b1;
        send_segment(1, 32'h5555, 16, 32, -1, 0);
        send_segment(0, 32'h6666, 16, 32, 6, 3);
        send_segment(1, 32'h7777, 16, 32, -1, 0);
        send_segment(0, 32'h1A2B, 16, 32, -1, 0);
        send_segment(1, 32'h3C4D, 16, 32, -1, 0);

        // Reset pulse inside a right word after a good left word
        send_segment(0, 32'h9999, 16, 32, -1, 0);
        send_segment(1, 32'h8888, 16, 32, 4, 1);
        send_segment(0, 32'hDEAD, 16, 32, -1, 0);
        send_segment(1, 32'hBEEF, 16, 32, -1, 0);

        // Random word lengths and data at a faster BCLK
        half = 4;
        for (int i = 0; i < 20; i++) begin
            send_random_segment(0);
            send_random_segment(1);
        end
        send_segment(0, 32'h0000, 16, 32, -1, 0);
        repeat (10) @(posedge clk);
        #1;

        chk("event_count", 64'(act_q.size()), 64'(exp_q.size()));
        dummy = mk_ev(0, 32'h0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size())
                chk($sformatf("event%0d", i), pack_ev(act_q[i]), pack_ev(exp_q[i]));
            else
                chk($sformatf("event%0d_missing", i), pack_ev(dummy), pack_ev(exp_q[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/i2s_rx_deser.md
# i2s_rx_deser

Front-end capture stage ahead of the delay/remix block: deserialises a Philips-format I2S stream from the ADC into one packed stereo word per frame, plus a one-cycle valid strobe. BCLK, LRCK and SDATA are treated as asynchronous and oversampled in the system clock domain. The packed output and strobe drive the delay stage's audio input and input-valid ports directly.

## Interface
- `DATA_W`, default 16: bits captured per channel; output word is 2*DATA_W bits.
- `clk`, input, 1: system clock; must give ≥3 clk periods per BCLK high phase and per BCLK low phase.
- `rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `enable`, input, 1: capture enable, synchronous to `clk`.
- `bclk`, input, 1: I2S bit clock, asynchronous.
- `lrck`, input, 1: I2S word select, asynchronous; 0 = left, 1 = right.
- `sdata`, input, 1: I2S serial data, MSB first, asynchronous.
- `audio_out`, output, 2*DATA_W: packed frame, {left[DATA_W-1:0], right[DATA_W-1:0]}.
- `valid_out`, output, 1: one-clk strobe; `audio_out` is new in that cycle.
- `frame_err`, output, 1: one-clk strobe; a channel word was short and the frame was dropped.

## Operation
- **Input synchronisers:** `bclk`, `lrck` and `sdata` each pass through a 2-flop synchroniser (`*_s1`, `*_s2`).
- **Edge detection:** a third flop `bclk_s3` detects the BCLK rising edge: `rise = bclk_s2 & ~bclk_s3`. All capture logic advances only on `rise` cycles and samples `lrck_s2` and `sdata_s2`.
- **State:**
  - `lr_prev`: LRCK at the previous rise.
  - `bit_cnt`: saturates at DATA_W.
  - `shreg`: DATA_W bits.
  - `left_hold`, `left_ok`.
  - `synced` flag.
- **On a rise with `lrck_s2 == lr_prev` (mid-word):**
  - If `bit_cnt < DATA_W`: shift `sdata_s2` into `shreg` LSB and increment `bit_cnt`.
  - Otherwise ignore the bit; extra bits are truncated.
- **On a rise with `lrck_s2 != lr_prev` (word boundary):** per Philips timing, this bit is the LSB slot of the outgoing channel.
  1. Shift it in first, under the same `bit_cnt < DATA_W` rule.
  2. Evaluate the completed word, with count = updated `bit_cnt`:
     - If `synced == 0`: set `synced`, discard the word.
     - Else if count < DATA_W (short word): pulse `frame_err`, clear `left_ok`, discard.
     - Else if `lr_prev == 0` (left finished): `left_hold <= word`, `left_ok <= 1`.
     - Else (right finished): if `left_ok`, then `audio_out <= {left_hold, word}` and pulse `valid_out`; then clear `left_ok`.
  3. Clear `bit_cnt` and `shreg`.
  4. `lr_prev <= lrck_s2`.
- **Right word with no valid left:** the frame is discarded silently, with no `frame_err`.
- **`enable == 0`:** synchronisers keep running, but all of the following are held at reset value:
  - `bit_cnt`, `shreg`, `left_ok`, `synced`, `valid_out`, `frame_err`.
  - `lr_prev` tracks `lrck_s2`.
  - `audio_out` holds its last value.
- **`enable` rising:** after it rises, the first LRCK edge only sets `synced`. The first `valid_out` therefore needs one complete left word plus one complete right word after that edge.
- **Output data:** raw two's-complement bits. No sign extension, scaling or saturation.

## Timing
- **Reset values:** `audio_out` = 0, `valid_out` = 0, `frame_err` = 0. All internal state is cleared, including `synced`, and the synchronisers reset to 0.
- **Reset mid-frame:** any partial word or held left word is lost. Resynchronisation is required exactly as after `enable` rising.
- **Latency:** `rise` is true in the cycle where `bclk_s2` is first high. This is 2 clk edges after `bclk` goes high, assuming setup is met.
  - `valid_out` / `frame_err` and the new `audio_out` are registered: they appear on the clk edge following the `rise` cycle, i.e. 3 clk edges after the BCLK pin rise that carried the LSB slot.
- **Strobe width:**
  - `valid_out` and `frame_err` are exactly 1 clk wide.
  - At most one of them fires per `rise`.
  - `audio_out` is stable until the next `valid_out`.
- **Input timing requirements:** LRCK and SDATA must be stable for ≥3 clk around each BCLK rise. LRCK changes only on BCLK falling edges.
- **Output throughput:** ≤1 `valid_out` per LRCK period, so the downstream stage needs no back-pressure.

## Test plan
- **Nominal frame:** DATA_W=16, 32 BCLK per channel, clk = 16× BCLK, left = 0x1234, right = 0xABCD, after one sync frame. Required: `audio_out` = 0x1234ABCD with a 1-clk `valid_out`, 3 clk after the BCLK rise carrying the right LSB slot.
- **Back-to-back frames:** left = 0x8000 / right = 0x7FFF, then left = 0xFFFF / right = 0x0001. Required: exactly two strobes, 0x80007FFF then 0xFFFF0001, with no `frame_err`.
- **Short word:** a left channel with only 10 BCLKs. Required: one `frame_err` pulse at the left→right boundary; the following right word produces no `valid_out`; the next complete frame recovers normally.
- **Sync and enable:** assert `enable` mid-word. Required: the first LRCK edge produces nothing, and the first `valid_out` comes at the end of the first complete L+R frame. Deasserting `enable` mid-frame suppresses all strobes.
- **Reset mid-frame:** pulse `rst_n` low for 2 clk during a right word. Required: all outputs are 0 immediately, and there is no strobe until a full sync edge plus L+R pair have completed.
- **Long words truncated:** 24 data bits per channel, left = 0xA5A5_5A, right = 0x0F0F_F0. Required: `audio_out` = 0xA5A50F0F, with no `frame_err`.
